// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, opcode/func, ALU and mux-select encodings for the multicycle MIPS controller
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// alu_dec: maps {aluop, func} to the ALU operation select
//  aluop   in  2  ADD / SUB / decode-from-func
//  func    in  6  R-type function field
//  alu_sel out 3  ALU operation
//  func_ok out 1  func is a supported R-type function (independent of aluop, so DECODE can screen it)
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] func,
  output logic [2:0] alu_sel,
  output logic       func_ok
);
  logic [2:0] fsel;
  always_comb begin
    fsel = func == FN_SUB ? ALU_SUB :
           func == FN_AND ? ALU_AND :
           func == FN_OR  ? ALU_OR  :
           func == FN_SLT ? ALU_SLT : ALU_ADD;
    func_ok = func == FN_ADD || func == FN_SUB || func == FN_AND || func == FN_OR || func == FN_SLT;
    alu_sel = aluop == ALUOP_FUNC ? fsel : aluop == ALUOP_SUB ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS main controller, one FSM state per cycle
//  clk, rst (async, active-low), halt, opcode[5:0], func[5:0], zero  -> inputs
//  PCEn IorD MemRead MemWrite MemtoReg IRWrite RegWrite RegDst ALUSrcA, PCSource[1:0],
//  ALUSrcB[1:0], ALUSel[2:0], inst_done, illegal, state_dbg[3:0]      -> outputs
//  MC_CTRL_PERF_EN: adds perf_cycles / perf_insts counters of width PERF_W
//  ILLEGAL_HALT=1 parks the FSM in IDLE after an illegal instruction until reset
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int PERF_W       = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  output logic        PCEn,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUSel,
  output logic        inst_done,
  output logic        illegal,
  output logic [3:0]  state_dbg
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_insts
`endif
);
  state_t     state_q, state_d, dec_nxt, done_nxt;
  logic       parked_q, pc_write, pc_cond, func_ok, op_ok;
  logic [1:0] aluop;
  logic [2:0] dec_sel;
  alu_dec u_alu_dec (.aluop(aluop), .func(func), .alu_sel(dec_sel), .func_ok(func_ok));
  assign op_ok = opcode == OP_LW || opcode == OP_SW || opcode == OP_BEQ || opcode == OP_ADDI ||
                 opcode == OP_J || (opcode == OP_RTYPE && func_ok);
  assign dec_nxt = !op_ok               ? (ILLEGAL_HALT ? IDLE : FETCH) :
                   opcode == OP_RTYPE   ? EXEC   :
                   opcode == OP_BEQ     ? BRANCH :
                   opcode == OP_ADDI    ? ADDIEX :
                   opcode == OP_J       ? JUMP   : MEMADR;
  assign done_nxt = halt ? IDLE : FETCH;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      parked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      parked_q <= parked_q | (ILLEGAL_HALT & illegal);
    end
  end
  always_comb begin
    state_d   = IDLE;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    ALUSrcA   = 1'b0;
    PCSource  = PCS_ALU;
    ALUSrcB   = SRCB_REG;
    inst_done = 1'b0;
    illegal   = 1'b0;
    pc_write  = 1'b0;
    pc_cond   = 1'b0;
    aluop     = ALUOP_ADD;
    case (state_q)
      IDLE:   state_d = (halt || parked_q) ? IDLE : FETCH;
      FETCH:  begin MemRead = 1'b1; IRWrite = 1'b1; ALUSrcB = SRCB_ONE; pc_write = 1'b1; state_d = DECODE; end
      DECODE: begin ALUSrcB = SRCB_IMM; illegal = !op_ok; state_d = dec_nxt; end
      MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; state_d = opcode == OP_SW ? MEMWR : MEMRD; end
      MEMRD:  begin IorD = 1'b1; MemRead = 1'b1; state_d = MEMWB; end
      MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; inst_done = 1'b1; state_d = done_nxt; end
      MEMWR:  begin IorD = 1'b1; MemWrite = 1'b1; inst_done = 1'b1; state_d = done_nxt; end
      EXEC:   begin ALUSrcA = 1'b1; aluop = ALUOP_FUNC; state_d = ALUWB; end
      ALUWB:  begin RegWrite = 1'b1; RegDst = 1'b1; inst_done = 1'b1; state_d = done_nxt; end
      ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; state_d = ADDIWB; end
      ADDIWB: begin RegWrite = 1'b1; inst_done = 1'b1; state_d = done_nxt; end
      BRANCH: begin ALUSrcA = 1'b1; aluop = ALUOP_SUB; PCSource = PCS_ALUOUT; pc_cond = 1'b1; inst_done = 1'b1; state_d = done_nxt; end
      JUMP:   begin PCSource = PCS_JUMP; pc_write = 1'b1; inst_done = 1'b1; state_d = done_nxt; end
      default: state_d = IDLE;
    endcase
  end
  // zero only matters in BRANCH, the sole Mealy path
  assign PCEn      = pc_write | (pc_cond & zero);
  assign ALUSel    = state_q == IDLE ? 3'b000 : dec_sel;
  assign state_dbg = state_q;
`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_insts  <= '0;
    end else begin
      perf_cycles <= perf_cycles + PERF_W'(state_q != IDLE);
      perf_insts  <= perf_insts + PERF_W'(inst_done);
    end
  end
`endif
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized and directed checks of mc_control_unit against an instruction-level model
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;
  logic clk, rst, halt, zero;
  logic [5:0] opcode, func;
  logic PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA, inst_done, illegal;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUSel;
  logic [3:0] state_dbg;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_insts;
`endif
  int checks = 0, failures = 0;
  logic [21:0] all_out;
  assign all_out = {PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
                    PCSource, ALUSrcB, ALUSel, inst_done, illegal, state_dbg};
  mc_control_unit dut (
    .clk(clk), .rst(rst), .halt(halt), .opcode(opcode), .func(func), .zero(zero),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUSel(ALUSel), .inst_done(inst_done),
    .illegal(illegal), .state_dbg(state_dbg)
`ifdef MC_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_insts(perf_insts)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_sel(input logic [5:0] fn);
    case (fn)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2A: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit r_ok(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the cycle after the instruction.
  task automatic run_inst(input logic [5:0] op, input logic [5:0] fn, input logic z, input int halt_cyc, input string nm);
    int lat = 2, rw_e = 0, mw_e = 0, mr_e = 1, pc_e = 1, ill_e = 0;
    int done_c = 0, n_done = 0, n_rw = 0, n_mw = 0, n_mr = 0, n_pc = 0, n_ill = 0, n_irw = 0, cyc = 0;
    logic wr_dst = 0, wr_m2r = 0, fetch_ok = 0;
    logic [2:0] sel = 0;
    logic [1:0] pcs = 0;
    bit fin = 0;
    case (op)
      6'h23: begin lat = 5; rw_e = 1; mr_e = 2; end
      6'h2B: begin lat = 4; mw_e = 1; end
      6'h08: begin lat = 4; rw_e = 1; end
      6'h04: begin lat = 3; pc_e = 1 + int'(z); end
      6'h02: begin lat = 3; pc_e = 2; end
      6'h00: if (r_ok(fn)) begin lat = 4; rw_e = 1; end else ill_e = 1;
      default: ill_e = 1;
    endcase
    while (!fin && cyc < 8) begin
      cyc++;
      if (cyc == halt_cyc) halt = 1'b1;
      opcode = op; func = fn; zero = z;
      #1;
      if (cyc == 1) fetch_ok = PCEn && IRWrite && MemRead && !IorD && !ALUSrcA && ALUSrcB == 2'd1 && ALUSel == 3'b010 && PCSource == 2'd0;
      n_done += int'(inst_done); n_rw += int'(RegWrite); n_mw += int'(MemWrite);
      n_mr += int'(MemRead); n_pc += int'(PCEn); n_ill += int'(illegal); n_irw += int'(IRWrite);
      if (RegWrite) begin wr_dst = RegDst; wr_m2r = MemtoReg; end
      if (cyc == 3) sel = ALUSel;
      if (inst_done) begin done_c = cyc; pcs = PCSource; end
      if (illegal) done_c = cyc;
      fin = inst_done || illegal;
      if (!fin) @(posedge clk);
    end
    checks++; if (done_c !== lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, done_c, lat); end
    checks++; if (n_done !== 1 - ill_e) begin failures++; $display("FAIL %s inst_done_count got=%0d exp=%0d", nm, n_done, 1 - ill_e); end
    checks++; if (n_ill !== ill_e) begin failures++; $display("FAIL %s illegal_count got=%0d exp=%0d", nm, n_ill, ill_e); end
    checks++; if (n_rw !== rw_e) begin failures++; $display("FAIL %s regwrite_count got=%0d exp=%0d", nm, n_rw, rw_e); end
    checks++; if (n_mw !== mw_e) begin failures++; $display("FAIL %s memwrite_count got=%0d exp=%0d", nm, n_mw, mw_e); end
    checks++; if (n_mr !== mr_e) begin failures++; $display("FAIL %s memread_count got=%0d exp=%0d", nm, n_mr, mr_e); end
    checks++; if (n_pc !== pc_e) begin failures++; $display("FAIL %s pcen_count got=%0d exp=%0d", nm, n_pc, pc_e); end
    checks++; if (n_irw !== 1) begin failures++; $display("FAIL %s irwrite_count got=%0d exp=1", nm, n_irw); end
    checks++; if (fetch_ok !== 1'b1) begin failures++; $display("FAIL %s fetch_strobes got=%b exp=1", nm, fetch_ok); end
    if (rw_e == 1) begin
      checks++; if (wr_dst !== (op == 6'h00)) begin failures++; $display("FAIL %s regdst got=%b exp=%b", nm, wr_dst, op == 6'h00); end
      checks++; if (wr_m2r !== (op == 6'h23)) begin failures++; $display("FAIL %s memtoreg got=%b exp=%b", nm, wr_m2r, op == 6'h23); end
    end
    if (op == 6'h00 && ill_e == 0) begin
      checks++; if (sel !== exp_sel(fn)) begin failures++; $display("FAIL %s exec_alusel got=%b exp=%b", nm, sel, exp_sel(fn)); end
    end
    if (op == 6'h04 || op == 6'h02) begin
      checks++; if (pcs !== (op == 6'h04 ? 2'd1 : 2'd2)) begin failures++; $display("FAIL %s pcsource got=%0d exp=%0d", nm, pcs, op == 6'h04 ? 1 : 2); end
    end
    @(posedge clk); #1;
    if (halt_cyc == 0) begin
      checks++; if (state_dbg !== 4'd1) begin failures++; $display("FAIL %s next_state got=%0d exp=1", nm, state_dbg); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; halt = 1'b0; opcode = '0; func = '0; zero = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
`ifdef MC_CTRL_PERF_EN
      checks++; if (perf_cycles !== 0 || perf_insts !== 0) begin failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_cycles, perf_insts); end
`endif
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (state_dbg !== 4'd0) begin failures++; $display("FAIL release_idle got=%0d exp=0", state_dbg); end
    @(posedge clk); #1;
    checks++; if (PCEn !== 1'b1 || IRWrite !== 1'b1 || state_dbg !== 4'd1) begin failures++; $display("FAIL first_fetch got=%b%b/%0d exp=11/1", PCEn, IRWrite, state_dbg); end
  endtask

  task automatic test_lw();
    run_inst(6'h23, 6'($urandom), 1'($urandom), 0, "lw");
  endtask

  task automatic test_branch();
    run_inst(6'h04, 6'($urandom), 1'b1, 0, "beq_taken");
    run_inst(6'h04, 6'($urandom), 1'b0, 0, "beq_not_taken");
  endtask

  task automatic test_rtype();
    run_inst(6'h00, 6'h22, 1'b0, 0, "r_sub");
    run_inst(6'h00, 6'h3F, 1'b0, 0, "r_bad_func");
    run_inst(6'h3F, 6'h20, 1'b0, 0, "bad_opcode");
  endtask

  task automatic test_halt();
    run_inst(6'h2B, 6'($urandom), 1'b0, 3, "sw_halt");
    checks++; if (all_out !== '0) begin failures++; $display("FAIL halt_idle got=%h exp=0", all_out); end
    @(posedge clk); #1;
    checks++; if (state_dbg !== 4'd0) begin failures++; $display("FAIL halt_hold got=%0d exp=0", state_dbg); end
    halt = 1'b0;
    @(posedge clk); #1;
    checks++; if (state_dbg !== 4'd1 || PCEn !== 1'b1) begin failures++; $display("FAIL halt_resume got=%0d/%b exp=1/1", state_dbg, PCEn); end
  endtask

  task automatic test_random();
    logic [5:0] ops [6] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] bad [5] = '{6'h01, 6'h03, 6'h05, 6'h0C, 6'h3F};
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 7);
      logic [5:0] op = k < 6 ? ops[k] : k == 6 ? bad[$urandom_range(0, 4)] : 6'h00;
      logic [5:0] fn = (k == 2) ? fns[$urandom_range(0, 4)] : (k == 7) ? 6'h3F : 6'($urandom);
      run_inst(op, fn, 1'($urandom), 0, "random");
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'h23; func = 6'h00; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (MemRead !== 1'b1 || IorD !== 1'b1 || state_dbg !== 4'd4) begin failures++; $display("FAIL memrd_reached got=%b%b/%0d exp=11/4", MemRead, IorD, state_dbg); end
    rst = 1'b0; #1;
    checks++; if (MemRead !== 1'b0 || state_dbg !== 4'd0 || all_out !== '0) begin failures++; $display("FAIL async_reset got=%h exp=0", all_out); end
    @(posedge clk); #1;
    checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_hold got=%h exp=0", all_out); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (state_dbg !== 4'd1) begin failures++; $display("FAIL reset_recover got=%0d exp=1", state_dbg); end
  endtask

`ifdef MC_CTRL_PERF_EN
  task automatic test_perf();
    rst = 1'b0; #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (perf_cycles !== 0 || state_dbg !== 4'd1) begin failures++; $display("FAIL perf_start got=%0d/%0d exp=0/1", perf_cycles, state_dbg); end
    run_inst(6'h02, 6'h00, 1'b0, 0, "perf_j");
    run_inst(6'h08, 6'h00, 1'b0, 0, "perf_addi");
    run_inst(6'h23, 6'h00, 1'b0, 1, "perf_lw");
    checks++; if (perf_insts !== 3) begin failures++; $display("FAIL perf_insts got=%0d exp=3", perf_insts); end
    checks++; if (perf_cycles !== 12) begin failures++; $display("FAIL perf_cycles got=%0d exp=12", perf_cycles); end
    halt = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_branch();
    test_rtype();
    test_halt();
    test_random();
    test_reset_mid();
`ifdef MC_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
